// File: rtl/tour_cmd_seq.sv
// Knight's-tour sequencer between the UART wrapper and cmd_proc: replays NUM_MOVES one-hot
// moves as vertical/horizontal commands, passing UART through when idle. Macro TOUR_TIMEOUT_EN adds a response watchdog.
module tour_cmd_seq #(
  parameter int         NUM_MOVES   = 24,
  parameter int         IDX_W       = $clog2(NUM_MOVES),
  parameter logic [3:0] VERT_OP     = 4'h2,
  parameter logic [3:0] HORZ_OP     = 4'h3,
  parameter logic [3:0] ABORT_OP    = 4'hF,
  parameter logic [7:0] HDG_N       = 8'h00,
  parameter logic [7:0] HDG_S       = 8'h7F,
  parameter logic [7:0] HDG_W       = 8'hBF,
  parameter logic [7:0] HDG_E       = 8'h3F,
  parameter logic [7:0] DONE_RESP   = 8'hA5,
  parameter logic [7:0] BUSY_RESP   = 8'h5A,
  parameter int         TIMEOUT_CYC = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             busy,
  output logic             aborted,
  output logic             bad_move,
  output logic             timeout
);

  typedef enum logic [2:0] {IDLE, LOAD, VERT, VERT_WAIT, HORZ, HORZ_WAIT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       vert_sq_q, vert_sq_d, horz_sq_q, horz_sq_d;
  logic [7:0]       vert_hdg_q, vert_hdg_d, horz_hdg_q, horz_hdg_d;
  logic             aborted_q, aborted_d, bad_move_q, bad_move_d;
  logic             timeout_q, timeout_d, abort_pend_q, abort_pend_d;

  logic [3:0] dec_vsq, dec_hsq;
  logic [7:0] dec_vhdg, dec_hhdg;
  logic       move_ok, last_mv, abort_req, in_wait, wd_expire;

  assign move_ok   = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);
  assign last_mv   = (idx_q == IDX_W'(NUM_MOVES - 1));
  assign abort_req = cmd_rdy_UART && (cmd_UART[15:12] == ABORT_OP);
  assign in_wait   = (state_q == VERT_WAIT) || (state_q == HORZ_WAIT);
  assign busy      = (state_q != IDLE);
  assign mv_indx   = idx_q;
  assign aborted   = aborted_q;
  assign bad_move  = bad_move_q;
  assign timeout   = timeout_q;

  always_comb begin
    dec_vsq  = 4'd2;
    dec_vhdg = HDG_N;
    dec_hsq  = 4'd1;
    dec_hhdg = HDG_E;
    case (move)
      8'h02: dec_hhdg = HDG_W;
      8'h04: begin dec_vsq = 4'd1; dec_hsq = 4'd2; end
      8'h08: begin dec_vsq = 4'd1; dec_vhdg = HDG_S; dec_hsq = 4'd2; end
      8'h10: dec_vhdg = HDG_S;
      8'h20: begin dec_vhdg = HDG_S; dec_hhdg = HDG_W; end
      8'h40: begin dec_vsq = 4'd1; dec_vhdg = HDG_S; dec_hsq = 4'd2; dec_hhdg = HDG_W; end
      8'h80: begin dec_vsq = 4'd1; dec_hsq = 4'd2; dec_hhdg = HDG_W; end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    vert_sq_d    = vert_sq_q;
    vert_hdg_d   = vert_hdg_q;
    horz_sq_d    = horz_sq_q;
    horz_hdg_d   = horz_hdg_q;
    aborted_d    = aborted_q;
    bad_move_d   = bad_move_q;
    timeout_d    = timeout_q;
    // abort is captured in any busy state; every exit to IDLE below overrides it
    abort_pend_d = abort_pend_q | (busy && abort_req);
    cmd          = cmd_UART;
    cmd_rdy      = cmd_rdy_UART;
    case (state_q)
      IDLE: begin
        if (start_tour) begin
          idx_d        = '0;
          aborted_d    = 1'b0;
          bad_move_d   = 1'b0;
          timeout_d    = 1'b0;
          abort_pend_d = 1'b0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        cmd        = {VERT_OP, vert_hdg_q, vert_sq_q};
        cmd_rdy    = 1'b0;
        vert_sq_d  = dec_vsq;
        vert_hdg_d = dec_vhdg;
        horz_sq_d  = dec_hsq;
        horz_hdg_d = dec_hhdg;
        if (!move_ok) begin
          bad_move_d   = 1'b1;
          abort_pend_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = VERT;
        end
      end
      VERT: begin
        cmd     = {VERT_OP, vert_hdg_q, vert_sq_q};
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = VERT_WAIT;
      end
      VERT_WAIT: begin
        cmd     = {VERT_OP, vert_hdg_q, vert_sq_q};
        cmd_rdy = 1'b0;
        if (send_resp) begin
          if (abort_pend_q) begin
            aborted_d    = 1'b1;
            abort_pend_d = 1'b0;
            state_d      = IDLE;
          end else begin
            state_d = HORZ;
          end
        end else if (wd_expire) begin
          timeout_d    = 1'b1;
          abort_pend_d = 1'b0;
          state_d      = IDLE;
        end
      end
      HORZ: begin
        cmd     = {HORZ_OP, horz_hdg_q, horz_sq_q};
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = HORZ_WAIT;
      end
      HORZ_WAIT: begin
        cmd     = {HORZ_OP, horz_hdg_q, horz_sq_q};
        cmd_rdy = 1'b0;
        if (send_resp) begin
          if (abort_pend_q || last_mv) begin
            aborted_d    = abort_pend_q;
            abort_pend_d = 1'b0;
            state_d      = IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = LOAD;
          end
        end else if (wd_expire) begin
          timeout_d    = 1'b1;
          abort_pend_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp = BUSY_RESP;
    if (!busy) resp = DONE_RESP;
    else if ((state_q == HORZ || state_q == HORZ_WAIT) && last_mv) resp = DONE_RESP;
    else if (in_wait && abort_pend_q) resp = DONE_RESP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      vert_sq_q    <= '0;
      vert_hdg_q   <= '0;
      horz_sq_q    <= '0;
      horz_hdg_q   <= '0;
      aborted_q    <= 1'b0;
      bad_move_q   <= 1'b0;
      timeout_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      vert_sq_q    <= vert_sq_d;
      vert_hdg_q   <= vert_hdg_d;
      horz_sq_q    <= horz_sq_d;
      horz_hdg_q   <= horz_hdg_d;
      aborted_q    <= aborted_d;
      bad_move_q   <= bad_move_d;
      timeout_q    <= timeout_d;
      abort_pend_q <= abort_pend_d;
    end
  end

`ifdef TOUR_TIMEOUT_EN
  logic [25:0] wd_q, wd_d;
  // restarts on every entry to a WAIT state, counts while staying there
  assign wd_d      = (in_wait && state_d == state_q) ? wd_q + 26'd1 : 26'd0;
  assign wd_expire = in_wait && (wd_q == 26'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign wd_expire          = 1'b0;
`endif

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Randomised bench for tour_cmd_seq: cmd_proc responder plus a handshake-level reference model
// checked every cycle, with literal expectations for the directed tours.
module tb_tour_cmd_seq;
  localparam int NUM = 24;
  localparam int TO  = 100;
  localparam int IW  = $clog2(NUM);

  logic          clk = 1'b0, rst = 1'b1, start_tour = 1'b0;
  logic          clr_cmd_rdy = 1'b0, send_resp = 1'b0, cmd_rdy_UART = 1'b0;
  logic [15:0]   cmd_UART = 16'h0000;
  logic [7:0]    move;
  logic [IW-1:0] mv_indx;
  logic [15:0]   cmd;
  logic          cmd_rdy, busy, aborted, bad_move, timeout;
  logic [7:0]    resp;
  logic [7:0]    tbl [NUM];

  always #5 clk = ~clk;
  assign move = (int'(mv_indx) < NUM) ? tbl[mv_indx] : 8'h00;

  tour_cmd_seq #(.NUM_MOVES(NUM), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp), .busy(busy),
    .aborted(aborted), .bad_move(bad_move), .timeout(timeout)
  );

  int n_vec = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Move bit -> (vertical squares, north?, horizontal squares, east?)
  function automatic logic [15:0] exp_cmd(input logic [7:0] mv, input bit horz);
    int vsq [8]; bit vn [8]; int hsq [8]; bit he [8]; int b;
    vsq = '{2, 2, 1, 1, 2, 2, 1, 1};
    vn  = '{1, 1, 1, 0, 0, 0, 0, 1};
    hsq = '{1, 1, 2, 2, 1, 1, 2, 2};
    he  = '{1, 0, 1, 1, 1, 0, 0, 0};
    b = 0;
    for (int i = 0; i < 8; i++) if (mv[i]) b = i;
    if (horz) return {4'h3, he[b] ? 8'h3F : 8'hBF, 4'(hsq[b])};
    return {4'h2, vn[b] ? 8'h00 : 8'h7F, 4'(vsq[b])};
  endfunction

  // Reference model: where the tour stands in terms of moves and command handshakes
  bit m_busy = 0, m_load = 0, m_offer = 0, m_wait = 0, m_horz = 0;
  bit m_abort = 0, m_ab = 0, m_bad = 0, m_to = 0;
  int m_idx = 0, m_wcyc = 0;
  logic [7:0] m_mv = 8'h00;
  bit chk_en = 0;

  task automatic m_end();
    m_busy = 0; m_load = 0; m_offer = 0; m_wait = 0; m_abort = 0;
  endtask

  always @(posedge clk) begin
    bit ab_req;
    ab_req = cmd_rdy_UART && (cmd_UART[15:12] == 4'hF);
    if (rst) begin
      m_end(); m_horz = 0; m_ab = 0; m_bad = 0; m_to = 0; m_idx = 0; m_wcyc = 0;
    end else if (!m_busy) begin
      if (start_tour) begin
        m_busy = 1; m_load = 1; m_idx = 0; m_ab = 0; m_bad = 0; m_to = 0; m_abort = 0;
      end
    end else begin
      if (m_load) begin
        m_mv = tbl[m_idx];
        m_load = 0;
        if ($countones(m_mv) != 1) begin m_bad = 1; m_end(); end
        else begin m_offer = 1; m_horz = 0; end
      end else if (m_offer) begin
        if (clr_cmd_rdy) begin m_offer = 0; m_wait = 1; m_wcyc = 0; end
      end else if (m_wait) begin
        if (send_resp) begin
          m_wait = 0;
          if (m_abort) begin m_ab = 1; m_end(); end
          else if (!m_horz) begin m_horz = 1; m_offer = 1; end
          else if (m_idx == NUM - 1) m_end();
          else begin m_idx++; m_load = 1; end
        end else begin
          m_wcyc++;
`ifdef TOUR_TIMEOUT_EN
          if (m_wcyc == TO) begin m_to = 1; m_end(); end
`endif
        end
      end
      if (m_busy && ab_req) m_abort = 1;
    end
  end

  always @(negedge clk) begin
    logic [15:0] ecmd; logic ecr; logic [7:0] eresp;
    if (chk_en) begin
      if (!m_busy) begin
        ecmd = cmd_UART; ecr = cmd_rdy_UART; eresp = 8'hA5;
      end else begin
        ecmd = exp_cmd(m_mv, m_horz); ecr = m_offer; eresp = 8'h5A;
        if ((m_offer || m_wait) && m_horz && m_idx == NUM - 1) eresp = 8'hA5;
        if (m_wait && m_abort) eresp = 8'hA5;
      end
      chk("busy", busy, m_busy);
      chk("mv_indx", mv_indx, m_idx);
      chk("cmd_rdy", cmd_rdy, ecr);
      if (!m_load) chk("cmd", cmd, ecmd);
      chk("resp", resp, eresp);
      chk("aborted", aborted, m_ab);
      chk("bad_move", bad_move, m_bad);
      chk("timeout", timeout, m_to);
    end
  end

  // cmd_proc stand-in and UART noise, updated 1 time unit after each rising edge
  int r_ph = 0, r_cnt = 0, r_pre = 0;
  int dly_min = 3, dly_max = 3, pre_max = 0;
  bit noise_en = 0, spur_en = 0, no_resp = 0;
  logic [15:0] got [$];

  task automatic step();
    @(posedge clk); #1;
    rst = 0; start_tour = 0; clr_cmd_rdy = 0; send_resp = 0;
    cmd_UART = {4'($urandom_range(0, 14)), 12'($urandom)};
    cmd_rdy_UART = noise_en && ($urandom_range(0, 3) == 0);
    if (r_ph == 0) begin
      if (busy && cmd_rdy) begin
        if (r_pre > 0) r_pre--;
        else begin
          clr_cmd_rdy = 1;
          got.push_back(cmd);
          if (spur_en && $urandom_range(0, 3) == 0) send_resp = 1;
          r_ph = 1;
          r_cnt = $urandom_range(dly_min, dly_max);
        end
      end
    end else if (r_cnt > 0) r_cnt--;
    else if (!no_resp) begin
      send_resp = 1; r_ph = 0; r_pre = $urandom_range(0, pre_max);
    end
  endtask

  task automatic run_tour(input int ab_cmd, input bit rnd_ev);
    bit ab_done; int cyc;
    ab_done = 0; cyc = 0;
    r_ph = 0; r_pre = 0; got.delete();
    step(); start_tour = 1;
    step();
    while (busy && cyc < 3000) begin
      step(); cyc++;
      if (ab_cmd >= 0 && !ab_done && r_ph == 1 && !clr_cmd_rdy && got.size() == ab_cmd) begin
        cmd_rdy_UART = 1; cmd_UART = 16'hF000; ab_done = 1;
      end
      if (rnd_ev && busy) begin
        if ($urandom_range(0, 150) == 0) begin cmd_rdy_UART = 1; cmd_UART = {4'hF, 12'($urandom)}; end
        if ($urandom_range(0, 40) == 0) start_tour = 1;
      end
    end
    chk("tour_ends_in_budget", busy, 0);
  endtask

  task automatic fill_tbl(input logic [7:0] v);
    for (int i = 0; i < NUM; i++) tbl[i] = v;
  endtask

  initial begin
    #900_000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  initial begin
    int wcnt, cyc;
    logic [7:0] bad_vals [4];
    bad_vals = '{8'h00, 8'h03, 8'hFF, 8'h81};
    fill_tbl(8'h01);
    repeat (2) @(posedge clk);
    #1 rst = 0; chk_en = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_resp", resp, 8'hA5);
    chk("rst_mv_indx", mv_indx, 0);
    chk("rst_flags", {aborted, bad_move, timeout}, 3'b000);
    chk("pin_v01", exp_cmd(8'h01, 0), 16'h2002);
    chk("pin_h01", exp_cmd(8'h01, 1), 16'h33F1);
    chk("pin_h40", exp_cmd(8'h40, 1), 16'h3BF2);
    chk("pin_v08", exp_cmd(8'h08, 0), 16'h27F1);

    step(); cmd_UART = 16'h2004; cmd_rdy_UART = 1; #1;
    chk("idle_cmd", cmd, 16'h2004);
    chk("idle_cmd_rdy", cmd_rdy, 1);
    noise_en = 1;
    repeat (8) step();
    noise_en = 0;

    // full tour, every move 8'h01, 3-cycle responses
    run_tour(-1, 0);
    chk("full_ncmd", got.size(), 48);
    for (int i = 0; i < got.size(); i++) chk("full_cmd_seq", got[i], (i % 2) ? 16'h33F1 : 16'h2002);
    chk("full_mv_indx", mv_indx, 23);

    // decode sweep: move i uses bit i%8
    for (int i = 0; i < NUM; i++) tbl[i] = 8'(1 << (i % 8));
    dly_min = 0; dly_max = 3; pre_max = 2; noise_en = 1; spur_en = 1;
    run_tour(-1, 0);
    chk("sweep_ncmd", got.size(), 48);
    if (got.size() >= 14) begin
      chk("sweep_v08", got[6], 16'h27F1);
      chk("sweep_h08", got[7], 16'h33F2);
      chk("sweep_v40", got[12], 16'h27F1);
      chk("sweep_h40", got[13], 16'h3BF2);
    end

    // illegal move at index 5
    fill_tbl(8'h01); tbl[5] = 8'h03;
    run_tour(-1, 0);
    chk("bad_flag", bad_move, 1);
    chk("bad_mv_indx", mv_indx, 5);
    chk("bad_ncmd", got.size(), 10);

    // abort while waiting on move 3's vertical response
    fill_tbl(8'h01); dly_min = 3; dly_max = 3; noise_en = 0; spur_en = 0;
    run_tour(7, 0);
    chk("abort_flag", aborted, 1);
    chk("abort_ncmd", got.size(), 7);

    // reset in the middle of a tour
    r_ph = 0; got.delete();
    step(); start_tour = 1;
    repeat (20) step();
    rst = 1;
    step(); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_mv_indx", mv_indx, 0);
    chk("midrst_resp", resp, 8'hA5);
    chk("midrst_cmd", cmd, cmd_UART);
    r_ph = 0;

`ifdef TOUR_TIMEOUT_EN
    no_resp = 1; r_ph = 0; r_pre = 0; got.delete();
    step(); start_tour = 1;
    step();
    wcnt = 0; cyc = 0;
    while (busy && cyc < 400) begin
      step(); cyc++;
      if (got.size() == 1 && !clr_cmd_rdy && busy) wcnt++;
    end
    chk("to_flag", timeout, 1);
    chk("to_wait_cycles", wcnt, TO);
    no_resp = 0; r_ph = 0;
`endif

    // randomised tours
    dly_min = 0; dly_max = 3; pre_max = 3; noise_en = 1; spur_en = 1;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < NUM; i++) tbl[i] = 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) tbl[$urandom_range(0, NUM - 1)] = bad_vals[$urandom_range(0, 3)];
      run_tour(-1, 1);
      repeat ($urandom_range(1, 4)) step();
    end
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tour_cmd_seq.md
# tour_cmd_seq

Parametrised knight's-tour command sequencer, sitting between the UART wrapper and cmd_proc. On `start_tour` it takes over the command path and walks `NUM_MOVES` one-hot moves from the tour store. Each move is decomposed into a vertical command and a horizontal command, and each command is handed to cmd_proc with a full rdy/clr/resp handshake. When idle it passes UART commands straight through. Over the previous generation it adds: configurable tour length and encodings, a one-cycle move-load state, illegal-move detection, a UART abort command, and an optional response watchdog.

## Interface
- `NUM_MOVES`, 24: moves per tour, ≥2; `IDX_W = $clog2(NUM_MOVES)`
- `VERT_OP`, 4'h2: opcode of vertical command
- `HORZ_OP`, 4'h3: opcode of horizontal command
- `ABORT_OP`, 4'hF: UART opcode that aborts a tour
- `HDG_N` / `HDG_S` / `HDG_W` / `HDG_E`, 8'h00 / 8'h7F / 8'hBF / 8'h3F: heading fields
- `DONE_RESP`, 8'hA5: response meaning done or idle
- `BUSY_RESP`, 8'h5A: response meaning tour in progress
- `TIMEOUT_CYC`, 50_000_000: watchdog limit in cycles; only used under `TOUR_TIMEOUT_EN`
- `clk`, in, 1: clock; the block uses one clock
- `rst`, in, 1: reset, synchronous and active-high
- `start_tour`, in, 1: one-cycle pulse that starts a tour
- `move`, in, 8: one-hot move addressed by `mv_indx`
- `mv_indx`, out, IDX_W: move address
- `cmd_UART`, in, 16: command from the UART wrapper
- `cmd_rdy_UART`, in, 1: command-ready from the UART wrapper
- `cmd`, out, 16: multiplexed command to cmd_proc, formatted {opcode[3:0], heading[7:0], squares[3:0]}
- `cmd_rdy`, out, 1: multiplexed command-ready to cmd_proc
- `clr_cmd_rdy`, in, 1: cmd_proc has consumed the command
- `send_resp`, in, 1: cmd_proc has finished the command
- `resp`, out, 8: response byte
- `busy`, out, 1: a tour is active
- `aborted`, out, 1: sticky; last tour ended by abort
- `bad_move`, out, 1: sticky; last tour ended on an illegal move
- `timeout`, out, 1: sticky; last tour ended by the watchdog (tied 0 without the macro)

## Operation
- States are IDLE, LOAD, VERT, VERT_WAIT, HORZ, HORZ_WAIT.
- **IDLE:**
  - `cmd = cmd_UART` and `cmd_rdy = cmd_rdy_UART`.
  - On `start_tour`: clear `mv_indx` and all three sticky flags, then go to LOAD.
- **LOAD:**
  - `move` must be valid in this cycle. It is registered as vert_sq, vert_hdg, horz_sq, horz_hdg.
  - If `move` is not one-hot: set `bad_move` and go to IDLE. Otherwise go to VERT.
- **Move decode** (bit: vertical, horizontal):
  - bit 0: 2N, 1E
  - bit 1: 2N, 1W
  - bit 2: 1N, 2E
  - bit 3: 1S, 2E
  - bit 4: 2S, 1E
  - bit 5: 2S, 1W
  - bit 6: 1S, 2W
  - bit 7: 1N, 2W
- **VERT / HORZ:**
  - `cmd = {VERT_OP or HORZ_OP, hdg, sq}`; `cmd_rdy = 1`.
  - On `clr_cmd_rdy`, go to the matching WAIT state.
- **WAIT states:** `cmd` is held and `cmd_rdy = 0`.
  - VERT_WAIT on `send_resp`: go to HORZ.
  - HORZ_WAIT on `send_resp`: if `mv_indx == NUM_MOVES-1` or an abort is pending, go to IDLE. Otherwise increment `mv_indx` and go to LOAD.
- **Abort:**
  - While busy, a `cmd_rdy_UART` with `cmd_UART[15:12] == ABORT_OP` sets abort_pend. The abort command is not forwarded.
  - At the next `send_resp` in either WAIT state: go to IDLE, set `aborted`, clear abort_pend.
- **UART during a tour:** non-abort UART commands are ignored while busy; `cmd_rdy_UART` is masked.
- **resp:**
  - `DONE_RESP` when not busy.
  - `DONE_RESP` in HORZ/HORZ_WAIT with `mv_indx == NUM_MOVES-1`.
  - `DONE_RESP` in any WAIT state with abort_pend set.
  - `BUSY_RESP` otherwise.
- **busy:** 1 in every state except IDLE.

## Timing
- **Reset values:**
  - state IDLE, `mv_indx` 0, `busy` 0, all sticky flags 0, abort_pend 0, watchdog count 0.
  - `resp = DONE_RESP`; `cmd`/`cmd_rdy` follow the UART inputs.
- `start_tour` at edge N: LOAD in cycle N+1, `cmd_rdy` first high in cycle N+2.
- Per-move overhead: one LOAD cycle, plus one cycle in each WAIT state minimum.
- `clr_cmd_rdy` and `send_resp` arriving in the same cycle in VERT/HORZ: `send_resp` is ignored; only `clr_cmd_rdy` advances the state.
- `start_tour` while busy: ignored.
- `rst` during a tour: immediately returns to IDLE with all reset values; it takes priority over every other input.
- Abort arriving in the same cycle as the final `send_resp`: the tour ends normally and `aborted` stays 0.
- `mv_indx` never exceeds `NUM_MOVES-1`; no wrap.

## Configuration
- Macro: `TOUR_TIMEOUT_EN`.
- **Defined:**
  - A 26-bit counter clears on entry to each WAIT state and counts while in it.
  - Reaching `TIMEOUT_CYC-1` without `send_resp` sets `timeout` and returns to IDLE.
  - `send_resp` in the same cycle as the limit wins.
- **Undefined:** no counter; WAIT states hold indefinitely; `timeout` is tied 0.

## Test plan
- Full tour, default parameters, all moves 8'h01, cmd_proc model responding in 3 cycles:
  - 48 commands alternate 16'h2002 and 16'h33F1.
  - `resp` is 8'h5A until the final HORZ, then 8'hA5.
  - `busy` falls after the 48th `send_resp`; `mv_indx` ends at 23.
- Decode sweep over all 8 one-hot moves:
  - 8'h40 yields 16'h27F1 then 16'h3BF2.
  - 8'h08 yields 16'h27F1 then 16'h33F2.
- Move 8'h03 at index 5: `bad_move = 1`, `busy = 0`, `mv_indx = 5`, no command issued.
- UART 16'hF000 during move 3 VERT_WAIT: the HORZ command is not issued; `aborted = 1`; `resp = 8'hA5` on that `send_resp`.
- With `TOUR_TIMEOUT_EN` and `TIMEOUT_CYC = 100`: no `send_resp` gives `timeout = 1` and IDLE after exactly 100 WAIT cycles.
- When idle, UART 16'h2004 with `cmd_rdy_UART` passes through unchanged; with `rst` pulsed mid-tour, all outputs return to reset values the next cycle.
